// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target receiver state encodings and the master's mode constants.
package i2c_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_DATA_ACK = 3'd4;
    localparam logic [2:0] ST_IGNORE   = 3'd5;

    typedef enum logic [2:0] {
        StIdle    = ST_IDLE,
        StAddr    = ST_ADDR,
        StAddrAck = ST_ADDR_ACK,
        StData    = ST_DATA,
        StDataAck = ST_DATA_ACK,
        StIgnore  = ST_IGNORE
    } rxState_t;

    // Master transmitter command modes, kept here so benches can share one package.
    localparam logic [1:0] START = 2'd0;
    localparam logic [1:0] BYTE  = 2'd1;
    localparam logic [1:0] STOP  = 2'd2;

endpackage

// File: rtl/i2c_line_filter.sv
// One-bit input conditioner: two-flop synchroniser followed by a DEBOUNCE-sample agreement filter.
module i2c_line_filter #(
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic inClock,
    input  logic reset,
    input  logic lineIn,
    output logic lineOut
);

    localparam logic [3:0] LAST = 4'(DEBOUNCE - 1);

    logic       meta;
    logic       sync;
    logic [3:0] count;

    // Counts consecutive synchronised samples that disagree with the filtered value.
    always_ff @(posedge inClock or negedge reset) begin
        if (!reset) begin
            meta    <= 1'b1;
            sync    <= 1'b1;
            count   <= 4'd0;
            lineOut <= 1'b1;
        end else begin
            meta <= lineIn;
            sync <= meta;
            if (sync == lineOut) begin
                count <= 4'd0;
            end else if (count == LAST) begin
                lineOut <= sync;
                count   <= 4'd0;
            end else begin
                count <= count + 4'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_target_rx.sv
// I2C write-only target: filters SCL/SDA, detects START/STOP, matches ADDR and ACKs received bytes.
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0]  ADDR     = 7'h1A,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic       inClock,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic       rxReady,
    output logic [7:0] dataOut,
    output logic       dataValid,
    output logic       addressed,
    output logic       startDetected,
    output logic       stopDetected
);

    logic       sclFilt;
    logic       sdaFilt;
    logic       sclPrev;
    logic       sdaPrev;
    logic       sclRise;
    logic       sclFall;
    logic       startEvent;
    logic       stopEvent;
    logic       sdaDrive;
    logic       lastBit;
    logic [3:0] bitCount;
    logic [7:0] shiftReg;
    logic [7:0] shiftNext;
    logic [7:0] rxByte;
    rxState_t   state;

    i2c_line_filter #(
        .DEBOUNCE (DEBOUNCE)
    ) u_scl_filter (
        .inClock (inClock),
        .reset   (reset),
        .lineIn  (scl),
        .lineOut (sclFilt)
    );

    i2c_line_filter #(
        .DEBOUNCE (DEBOUNCE)
    ) u_sda_filter (
        .inClock (inClock),
        .reset   (reset),
        .lineIn  (sda),
        .lineOut (sdaFilt)
    );

    // Open drain: only ever pull low; the async clear of sdaDrive frees the bus on reset.
    assign sda = sdaDrive ? 1'b0 : 1'bz;

    always_ff @(posedge inClock or negedge reset) begin
        if (!reset) begin
            sclPrev <= 1'b1;
            sdaPrev <= 1'b1;
        end else begin
            sclPrev <= sclFilt;
            sdaPrev <= sdaFilt;
        end
    end

    // Our own ACK drive must never look like a START or STOP.
    always_comb begin
        sclRise    = sclFilt & ~sclPrev;
        sclFall    = ~sclFilt & sclPrev;
        startEvent = sclFilt & sclPrev & sdaPrev & ~sdaFilt & ~sdaDrive;
        stopEvent  = sclFilt & sclPrev & ~sdaPrev & sdaFilt & ~sdaDrive;
        shiftNext  = {shiftReg[6:0], sdaFilt};
        lastBit    = (bitCount == 4'd7);
    end

    always_ff @(posedge inClock or negedge reset) begin
        if (!reset) begin
            state         <= StIdle;
            sdaDrive      <= 1'b0;
            bitCount      <= 4'd0;
            shiftReg      <= 8'h00;
            rxByte        <= 8'h00;
            dataOut       <= 8'h00;
            dataValid     <= 1'b0;
            addressed     <= 1'b0;
            startDetected <= 1'b0;
            stopDetected  <= 1'b0;
        end else begin
            dataValid     <= 1'b0;
            startDetected <= 1'b0;
            stopDetected  <= 1'b0;
            if (stopEvent) begin
                sdaDrive     <= 1'b0;
                addressed    <= 1'b0;
                bitCount     <= 4'd0;
                stopDetected <= 1'b1;
                state        <= StIdle;
            end else if (startEvent) begin
                sdaDrive      <= 1'b0;
                addressed     <= 1'b0;
                bitCount      <= 4'd0;
                startDetected <= 1'b1;
                state         <= StAddr;
            end else begin
                case (state)
                    StIdle: begin
                    end
                    StAddr: begin
                        if (sclRise) begin
                            shiftReg <= shiftNext;
                            bitCount <= bitCount + 4'd1;
                            if (lastBit) begin
                                if (shiftNext[7:1] == ADDR && !shiftNext[0]) begin
                                    state <= StAddrAck;
                                end else begin
                                    bitCount <= 4'd0;
                                    state    <= StIgnore;
                                end
                            end
                        end
                    end
                    StAddrAck: begin
                        // First fall opens the ACK slot, second fall closes it.
                        if (sclFall) begin
                            if (!sdaDrive) begin
                                sdaDrive <= 1'b1;
                            end else begin
                                sdaDrive  <= 1'b0;
                                addressed <= 1'b1;
                                bitCount  <= 4'd0;
                                state     <= StData;
                            end
                        end
                    end
                    StData: begin
                        if (sclRise) begin
                            shiftReg <= shiftNext;
                            bitCount <= bitCount + 4'd1;
                            if (lastBit) begin
                                rxByte <= shiftNext;
                                if (rxReady) begin
                                    state <= StDataAck;
                                end else begin
                                    addressed <= 1'b0;
                                    bitCount  <= 4'd0;
                                    state     <= StIgnore;
                                end
                            end
                        end
                    end
                    StDataAck: begin
                        if (sclFall) begin
                            if (!sdaDrive) begin
                                sdaDrive  <= 1'b1;
                                dataOut   <= rxByte;
                                dataValid <= 1'b1;
                            end else begin
                                sdaDrive <= 1'b0;
                                bitCount <= 4'd0;
                                state    <= StData;
                            end
                        end
                    end
                    StIgnore: begin
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: table of write transactions plus restart, glitch and reset cases.
module tb_i2c_target_rx;

    localparam int Q = 10;
    localparam int H = 20;

    logic       inClock = 1'b0;
    logic       reset   = 1'b0;
    logic       scl     = 1'b1;
    logic       tbLow   = 1'b0;
    logic       rxReady = 1'b1;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       addressed;
    logic       startDetected;
    logic       stopDetected;
    wire        sda;

    pullup (sda);
    assign sda = tbLow ? 1'b0 : 1'bz;

    i2c_target_rx #(
        .ADDR     (7'h1A),
        .DEBOUNCE (3)
    ) dut (
        .inClock       (inClock),
        .reset         (reset),
        .scl           (scl),
        .sda           (sda),
        .rxReady       (rxReady),
        .dataOut       (dataOut),
        .dataValid     (dataValid),
        .addressed     (addressed),
        .startDetected (startDetected),
        .stopDetected  (stopDetected)
    );

    always #5 inClock = ~inClock;

    int         total = 0;
    int         bad   = 0;
    int         validCnt = 0;
    int         startCnt = 0;
    int         stopCnt  = 0;
    logic [7:0] lastData = 8'h00;

    always @(negedge inClock) begin
        if (reset) begin
            if (dataValid) begin
                validCnt = validCnt + 1;
                lastData = dataOut;
            end
            if (startDetected) startCnt = startCnt + 1;
            if (stopDetected)  stopCnt  = stopCnt + 1;
        end
    end

    typedef struct {
        logic [7:0] addr;
        int         n;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       r0;
        logic       r1;
        logic       expAddrAck;
        logic       expAck0;
        logic       expAck1;
        int         expValid;
        logic [7:0] expLast;
        logic       expAddressed;
    } vec_t;

    vec_t vecs[6];

    task automatic cyc(input int n);
        repeat (n) @(negedge inClock);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sendBit(input logic b, input int glitchAt);
        cyc(Q);
        tbLow = ~b;
        cyc(Q);
        scl = 1'b1;
        if (glitchAt > 0) begin
            cyc(glitchAt);
            scl = 1'b0;
            cyc(1);
            scl = 1'b1;
            cyc(H - glitchAt - 1);
        end else begin
            cyc(H);
        end
        scl = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sendBit(b[i], 0);
    endtask

    task automatic ackSlot(output logic s);
        cyc(Q);
        tbLow = 1'b0;
        cyc(Q);
        scl = 1'b1;
        cyc(H / 2);
        s = sda;
        cyc(H / 2);
        scl = 1'b0;
        cyc(10);
    endtask

    task automatic startCond();
        tbLow = 1'b1;
        cyc(H);
        scl = 1'b0;
    endtask

    task automatic repStart();
        cyc(Q);
        tbLow = 1'b0;
        cyc(Q);
        scl = 1'b1;
        cyc(H);
        tbLow = 1'b1;
        cyc(H);
        scl = 1'b0;
    endtask

    task automatic stopCond();
        cyc(Q);
        tbLow = 1'b1;
        cyc(Q);
        scl = 1'b1;
        cyc(H);
        tbLow = 1'b0;
        cyc(H);
    endtask

    initial begin
        logic       a;
        int         v0;
        int         s0;
        int         p0;
        logic [7:0] partial;

        vecs[0] = '{8'h34, 1, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 8'hA5, 1'b1};
        vecs[1] = '{8'h36, 1, 8'h55, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 8'h00, 1'b0};
        vecs[2] = '{8'h35, 0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 8'h00, 1'b0};
        vecs[3] = '{8'h34, 2, 8'h11, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8'h11, 1'b1};
        vecs[4] = '{8'h34, 2, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 8'hFF, 1'b1};
        vecs[5] = '{8'hB4, 1, 8'hAA, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 8'h00, 1'b0};

        cyc(5);
        check("rst dataOut", dataOut, 8'h00);
        check("rst dataValid", dataValid, 1'b0);
        check("rst addressed", addressed, 1'b0);
        check("rst start", startDetected, 1'b0);
        check("rst stop", stopDetected, 1'b0);
        check("rst sda", sda, 1'b1);
        reset = 1'b1;
        cyc(20);

        for (int i = 0; i < 6; i++) begin
            v0 = validCnt;
            s0 = startCnt;
            p0 = stopCnt;
            startCond();
            sendByte(vecs[i].addr);
            ackSlot(a);
            check($sformatf("v%0d addr ack", i), a, vecs[i].expAddrAck);
            check($sformatf("v%0d addressed", i), addressed, vecs[i].expAddressed);
            for (int k = 0; k < vecs[i].n; k++) begin
                rxReady = (k == 0) ? vecs[i].r0 : vecs[i].r1;
                sendByte((k == 0) ? vecs[i].d0 : vecs[i].d1);
                ackSlot(a);
                check($sformatf("v%0d data%0d ack", i, k), a,
                      (k == 0) ? vecs[i].expAck0 : vecs[i].expAck1);
            end
            rxReady = 1'b1;
            stopCond();
            cyc(10);
            check($sformatf("v%0d valid count", i), validCnt - v0, vecs[i].expValid);
            if (vecs[i].expValid > 0) check($sformatf("v%0d dataOut", i), lastData, vecs[i].expLast);
            check($sformatf("v%0d start pulses", i), startCnt - s0, 1);
            check($sformatf("v%0d stop pulses", i), stopCnt - p0, 1);
            check($sformatf("v%0d addressed after stop", i), addressed, 1'b0);
        end

        // Repeated START after half a data byte: partial byte must be dropped.
        v0 = validCnt;
        s0 = startCnt;
        p0 = stopCnt;
        partial = 8'hB0;
        startCond();
        sendByte(8'h34);
        ackSlot(a);
        check("rs first addr ack", a, 1'b0);
        for (int i = 7; i >= 4; i--) sendBit(partial[i], 0);
        repStart();
        check("rs addressed cleared", addressed, 1'b0);
        sendByte(8'h34);
        ackSlot(a);
        check("rs second addr ack", a, 1'b0);
        sendByte(8'h7E);
        ackSlot(a);
        check("rs data ack", a, 1'b0);
        stopCond();
        cyc(10);
        check("rs start pulses", startCnt - s0, 2);
        check("rs stop pulses", stopCnt - p0, 1);
        check("rs valid count", validCnt - v0, 1);
        check("rs dataOut", lastData, 8'h7E);

        // One-cycle low glitch on SCL during a high phase must not clock a bit.
        v0 = validCnt;
        startCond();
        sendByte(8'h34);
        ackSlot(a);
        partial = 8'h5A;
        for (int i = 7; i >= 0; i--) sendBit(partial[i], (i == 4) ? 8 : 0);
        ackSlot(a);
        check("glitch data ack", a, 1'b0);
        stopCond();
        cyc(10);
        check("glitch valid count", validCnt - v0, 1);
        check("glitch dataOut", lastData, 8'h5A);

        // Reset inside the data ACK window releases SDA without a clock edge.
        startCond();
        sendByte(8'h34);
        ackSlot(a);
        sendByte(8'h3C);
        cyc(Q);
        tbLow = 1'b0;
        cyc(2);
        check("ack window sda low", sda, 1'b0);
        check("ack window dataOut", dataOut, 8'h3C);
        check("ack window addressed", addressed, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("reset sda released", sda, 1'b1);
        check("reset dataOut", dataOut, 8'h00);
        check("reset addressed", addressed, 1'b0);
        check("reset dataValid", dataValid, 1'b0);
        check("reset start", startDetected, 1'b0);
        check("reset stop", stopDetected, 1'b0);
        scl = 1'b1;
        cyc(5);
        reset = 1'b1;
        cyc(20);

        // Bus still usable after the mid-transfer reset.
        v0 = validCnt;
        startCond();
        sendByte(8'h34);
        ackSlot(a);
        check("post-reset addr ack", a, 1'b0);
        sendByte(8'hC3);
        ackSlot(a);
        stopCond();
        cyc(10);
        check("post-reset valid count", validCnt - v0, 1);
        check("post-reset dataOut", lastData, 8'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
